// File: rtl/axi_cnt_writer.sv
// Periodic AXI write master: every PERIOD enabled cycles it writes the running count
// into the next slave register, round-robin. Optional macro CNT_WR_TIMEOUT_EN adds a B-channel timeout.
module axi_cnt_writer #(
    parameter logic [3:0] AXI_ID   = 4'h0,
    parameter int         PERIOD   = 16,
    parameter int         NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en_i,
    output logic [31:0] cnt_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        ovf_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);

    localparam int TICK_W = $clog2(PERIOD);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t             state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]   reg_idx;
    logic [IDX_W-1:0]   awaddr_q;
    logic               tick;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               aw_done;
    logic               w_done;
    logic               resp_bad;
`ifdef CNT_WR_TIMEOUT_EN
    logic [5:0]         to_cnt;
`endif

    assign awid_o   = AXI_ID;
    assign wid_o    = AXI_ID;
    assign wstrb_o  = 4'hF;
    assign wlast_o  = 1'b1;
    assign awaddr_o = 32'(awaddr_q);
    assign busy_o   = (state != IDLE);

    assign tick     = en_i && (tick_cnt == TICK_LAST);
    assign aw_hs    = awvalid_o && awready_i;
    assign w_hs     = wvalid_o && wready_i;
    assign b_hs     = bvalid_i && bready_o;
    // A channel counts as done if it already finished or finishes this cycle.
    assign aw_done  = !awvalid_o || awready_i;
    assign w_done   = !wvalid_o || wready_i;
    assign resp_bad = (bresp_i != 2'b00) || (bid_i != AXI_ID);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tick_cnt <= '0;
        end else if (!en_i || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= IDLE;
            cnt_o     <= '0;
            reg_idx   <= '0;
            awaddr_q  <= '0;
            wdata_o   <= '0;
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b0;
            err_o     <= 1'b0;
            ovf_o     <= 1'b0;
`ifdef CNT_WR_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            if (tick && state != IDLE) begin
                ovf_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        wdata_o   <= cnt_o;
                        awaddr_q  <= reg_idx;
                        cnt_o     <= cnt_o + 32'd1;
                        awvalid_o <= 1'b1;
                        wvalid_o  <= 1'b1;
                        state     <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_o <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_o <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_o <= 1'b1;
                        state    <= RESP;
`ifdef CNT_WR_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bready_o <= 1'b0;
                        reg_idx  <= (reg_idx == IDX_LAST) ? '0 : reg_idx + IDX_W'(1);
                        state    <= IDLE;
                        if (resp_bad) begin
                            err_o <= 1'b1;
                        end
                    end
`ifdef CNT_WR_TIMEOUT_EN
                    // Give up on a silent slave; the same register is retried next tick.
                    else if (to_cnt == 6'd63) begin
                        err_o    <= 1'b1;
                        bready_o <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 6'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
